timer_ctrl_master: RTL and testbench
====================================

// Module: timer_ctrl_master
// PURPOSE
//  Avalon-MM initiator that owns the interval-timer slave: programs its 32-bit period, starts/stops it,
//  acknowledges timeout IRQs and fetches counter snapshots. Sits between the ECU scheduler logic and the
//  timer's s1 port (3-bit word address, 16-bit data, no waitrequest, readdata registered 1 cycle).
// PARAMETERS
//  CNT_W     16  width of tick_count (timeouts acknowledged), wraps modulo 2**CNT_W
//  CTL_ITO    1  value written to control ITO bit on start (1 = timer IRQ enabled)
// PORTS
//  clk             in   1      system clock
//  reset           in   1      asynchronous, active-high reset
//  cfg_start       in   1      pulse: program cfg_period then start timer
//  cfg_stop        in   1      pulse: stop timer
//  cfg_snap        in   1      pulse: capture and read counter snapshot
//  cfg_period      in   32     period, sampled when start request is accepted from IDLE
//  cfg_continuous  in   1      CONT bit, sampled with cfg_period
//  timer_irq       in   1      timer interrupt (level)
//  avm_address     out  3      word address to timer
//  avm_chipselect  out  1      slave select
//  avm_write_n     out  1      active-low write strobe
//  avm_writedata   out  16     write data
//  avm_readdata    in   16     read data, valid the cycle after address presented
//  busy            out  1      FSM not in IDLE
//  running         out  1      1 after start sequence completes, 0 after stop sequence
//  tick            out  1      1-cycle pulse per acknowledged timeout
//  tick_count      out  CNT_W  acknowledged timeouts since reset
//  snap_valid      out  1      1-cycle pulse, snap_value updated
//  snap_value      out  32     last snapshot {SNAPH,SNAPL}
// BEHAVIOUR
//  Register map driven: 0 STATUS (any write clears TO), 1 CONTROL {STOP,START,CONT,ITO}, 2 PERIODL,
//   3 PERIODH, 4 SNAPL, 5 SNAPH (write to 4 captures counter).
//  Reset: chipselect=0, write_n=1, address=0, writedata=0, busy=0, running=0, tick=0, tick_count=0,
//   snap_valid=0, snap_value=0, all pending flags 0, FSM=IDLE. Reset mid-sequence aborts with no further bus cycle.
//  cfg_start/stop/snap set sticky pending flags every cycle (also while busy); flag clears when its sequence
//   is entered. Same-cycle request and entry: flag stays clear.
//  IDLE priority: stop > start > irq (timer_irq=1) > snap. One bus access per cycle; chipselect=1 only in
//   access states; write_n=0 only in write states.
//  Start: WR_PL(addr2,period[15:0]) -> WR_PH(addr3,period[31:16]) -> WR_CTL(addr1,{0,1,CONT,CTL_ITO})
//   -> IDLE, running=1 on exit. Period writes must precede control (period write force-reloads and stops timer).
//  Stop: WR_STOP(addr1, 16'h0008) -> IDLE, running=0. Stop pending also cancels a pending start.
//  IRQ: WR_ACK(addr0, 16'h0000) -> ACK_GAP (chipselect=0, 1 cycle; irq still settling) -> IDLE; tick pulses
//   and tick_count increments on WR_ACK exit. timer_irq ignored outside IDLE; no double count.
//  Snap: WR_SNAP(addr4,0) -> RD_SL(addr4, read) -> RD_SH(addr5, read; capture readdata as low half)
//   -> RD_DONE(chipselect=0; capture readdata as high half, snap_value updated, snap_valid=1) -> IDLE.
//  Latencies from request pulse in IDLE: start 3 bus cycles, stop 1, ack 2, snap 4; busy=1 throughout.
//  Outputs registered; avm_* change only on clk edges.
// STRUCTURE
//  Package timer_pkg: register address localparams (TMR_STATUS..TMR_SNAPH), control bit indices,
//   state enum. Single module, no sub-module; FSM + pending flags + capture registers inline.
// TESTING
//  Reset then hold -> all outputs at reset values, chipselect=0 for 20 cycles.
//  cfg_start, period=32'h0001_86A0, cont=1 -> writes (2,86A0),(3,0001),(1,0007) consecutive; running=1.
//  Model timer asserts irq -> one write (0,0000), tick=1 once, tick_count 0->1; irq held 1 extra cycle no recount.
//  cfg_snap with model counter 32'h0000_1234 -> write(4), reads 4,5; snap_value=32'h0000_1234, snap_valid 1 cycle.
//  cfg_start and cfg_stop same cycle -> only (1,0008) written, running=0, no period writes.
//  cfg_snap during start sequence -> snap runs after WR_CTL; reset asserted in RD_SH -> chipselect=0 next cycle.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the interval-timer bus master: timer register map,
// CONTROL bit positions, master FSM states and the CONTROL word builder.
package timer_pkg;

    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_PERIODH = 3'd3;
    localparam logic [2:0] TMR_SNAPL   = 3'd4;
    localparam logic [2:0] TMR_SNAPH   = 3'd5;

    localparam int CTL_BIT_ITO   = 0;
    localparam int CTL_BIT_CONT  = 1;
    localparam int CTL_BIT_START = 2;
    localparam int CTL_BIT_STOP  = 3;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WR_PL   = 4'd1,
        ST_WR_PH   = 4'd2,
        ST_WR_CTL  = 4'd3,
        ST_WR_STOP = 4'd4,
        ST_WR_ACK  = 4'd5,
        ST_ACK_GAP = 4'd6,
        ST_WR_SNAP = 4'd7,
        ST_RD_SL   = 4'd8,
        ST_RD_SH   = 4'd9,
        ST_RD_DONE = 4'd10
    } state_e;

    function automatic logic [15:0] ctl_word(input logic stop, input logic start,
                                             input logic cont, input logic ito);
        logic [15:0] w;
        w                = 16'h0000;
        w[CTL_BIT_STOP]  = stop;
        w[CTL_BIT_START] = start;
        w[CTL_BIT_CONT]  = cont;
        w[CTL_BIT_ITO]   = ito;
        return w;
    endfunction

endpackage

// File: rtl/timer_ctrl_master.sv
// Avalon-MM initiator for the interval timer: programs period/control, acknowledges
// timeouts and reads counter snapshots, one bus access per cycle with registered outputs.
module timer_ctrl_master
    import timer_pkg::*;
#(
    parameter int   CNT_W   = 16,
    parameter logic CTL_ITO = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic             cfg_stop,
    input  logic             cfg_snap,
    input  logic [31:0]      cfg_period,
    input  logic             cfg_continuous,
    input  logic             timer_irq,
    output logic [2:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [15:0]      avm_writedata,
    input  logic [15:0]      avm_readdata,
    output logic             busy,
    output logic             running,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    output logic             snap_valid,
    output logic [31:0]      snap_value
);

    state_e            state_r;
    state_e            state_nxt_s;
    logic              pend_start_r;
    logic              pend_stop_r;
    logic              pend_snap_r;
    logic              req_start_s;
    logic              req_stop_s;
    logic              req_snap_s;
    logic              enter_start_s;
    logic              enter_stop_s;
    logic              enter_snap_s;
    logic [31:0]       period_r;
    logic              cont_r;
    logic [15:0]       snap_lo_r;
    logic [2:0]        addr_nxt_s;
    logic              cs_nxt_s;
    logic              write_n_nxt_s;
    logic [15:0]       wdata_nxt_s;
    logic [2:0]        avm_address_r;
    logic              avm_chipselect_r;
    logic              avm_write_n_r;
    logic [15:0]       avm_writedata_r;
    logic              busy_r;
    logic              running_r;
    logic              tick_r;
    logic [CNT_W-1:0]  tick_count_r;
    logic              snap_valid_r;
    logic [31:0]       snap_value_r;

    // Requests that arrive in the same cycle they are accepted never leave a stale flag.
    assign req_start_s = pend_start_r | cfg_start;
    assign req_stop_s  = pend_stop_r  | cfg_stop;
    assign req_snap_s  = pend_snap_r  | cfg_snap;

    // Next-state selection with IDLE arbitration stop > start > irq > snap.
    always_comb begin
        state_nxt_s   = state_r;
        enter_start_s = 1'b0;
        enter_stop_s  = 1'b0;
        enter_snap_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_stop_s) begin
                    state_nxt_s  = ST_WR_STOP;
                    enter_stop_s = 1'b1;
                end else if (req_start_s) begin
                    state_nxt_s   = ST_WR_PL;
                    enter_start_s = 1'b1;
                end else if (timer_irq) begin
                    state_nxt_s = ST_WR_ACK;
                end else if (req_snap_s) begin
                    state_nxt_s  = ST_WR_SNAP;
                    enter_snap_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR_PL:   state_nxt_s = ST_WR_PH;
            ST_WR_PH:   state_nxt_s = ST_WR_CTL;
            ST_WR_CTL:  state_nxt_s = ST_IDLE;
            ST_WR_STOP: state_nxt_s = ST_IDLE;
            ST_WR_ACK:  state_nxt_s = ST_ACK_GAP;
            ST_ACK_GAP: state_nxt_s = ST_IDLE;
            ST_WR_SNAP: state_nxt_s = ST_RD_SL;
            ST_RD_SL:   state_nxt_s = ST_RD_SH;
            ST_RD_SH:   state_nxt_s = ST_RD_DONE;
            ST_RD_DONE: state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Bus drive for the state being entered; registered below so avm_* only move on edges.
    always_comb begin
        addr_nxt_s    = 3'd0;
        cs_nxt_s      = 1'b0;
        write_n_nxt_s = 1'b1;
        wdata_nxt_s   = 16'h0000;
        case (state_nxt_s)
            ST_WR_PL: begin
                cs_nxt_s      = 1'b1;
                write_n_nxt_s = 1'b0;
                addr_nxt_s    = TMR_PERIODL;
                wdata_nxt_s   = enter_start_s ? cfg_period[15:0] : period_r[15:0];
            end
            ST_WR_PH: begin
                cs_nxt_s      = 1'b1;
                write_n_nxt_s = 1'b0;
                addr_nxt_s    = TMR_PERIODH;
                wdata_nxt_s   = period_r[31:16];
            end
            ST_WR_CTL: begin
                cs_nxt_s      = 1'b1;
                write_n_nxt_s = 1'b0;
                addr_nxt_s    = TMR_CONTROL;
                wdata_nxt_s   = ctl_word(1'b0, 1'b1, cont_r, CTL_ITO);
            end
            ST_WR_STOP: begin
                cs_nxt_s      = 1'b1;
                write_n_nxt_s = 1'b0;
                addr_nxt_s    = TMR_CONTROL;
                wdata_nxt_s   = ctl_word(1'b1, 1'b0, 1'b0, 1'b0);
            end
            ST_WR_ACK: begin
                cs_nxt_s      = 1'b1;
                write_n_nxt_s = 1'b0;
                addr_nxt_s    = TMR_STATUS;
            end
            ST_WR_SNAP: begin
                cs_nxt_s      = 1'b1;
                write_n_nxt_s = 1'b0;
                addr_nxt_s    = TMR_SNAPL;
            end
            ST_RD_SL: begin
                cs_nxt_s   = 1'b1;
                addr_nxt_s = TMR_SNAPL;
            end
            ST_RD_SH: begin
                cs_nxt_s   = 1'b1;
                addr_nxt_s = TMR_SNAPH;
            end
            default: begin
                cs_nxt_s = 1'b0;
            end
        endcase
    end

    // State, pending flags, captured configuration and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            pend_start_r     <= 1'b0;
            pend_stop_r      <= 1'b0;
            pend_snap_r      <= 1'b0;
            period_r         <= 32'h0000_0000;
            cont_r           <= 1'b0;
            snap_lo_r        <= 16'h0000;
            avm_address_r    <= 3'd0;
            avm_chipselect_r <= 1'b0;
            avm_write_n_r    <= 1'b1;
            avm_writedata_r  <= 16'h0000;
            busy_r           <= 1'b0;
            running_r        <= 1'b0;
            tick_r           <= 1'b0;
            tick_count_r     <= {CNT_W{1'b0}};
            snap_valid_r     <= 1'b0;
            snap_value_r     <= 32'h0000_0000;
        end else begin
            state_r          <= state_nxt_s;
            pend_stop_r      <= req_stop_s & ~enter_stop_s;
            // A stop taken from IDLE also discards any start waiting behind it.
            pend_start_r     <= req_start_s & ~enter_start_s & ~enter_stop_s;
            pend_snap_r      <= req_snap_s & ~enter_snap_s;
            avm_address_r    <= addr_nxt_s;
            avm_chipselect_r <= cs_nxt_s;
            avm_write_n_r    <= write_n_nxt_s;
            avm_writedata_r  <= wdata_nxt_s;
            busy_r           <= (state_nxt_s != ST_IDLE);
            tick_r           <= (state_r == ST_WR_ACK);
            snap_valid_r     <= (state_r == ST_RD_DONE);
            if (enter_start_s) begin
                period_r <= cfg_period;
                cont_r   <= cfg_continuous;
            end
            if (state_r == ST_WR_ACK) begin
                tick_count_r <= tick_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (state_r == ST_RD_SH) begin
                snap_lo_r <= avm_readdata;
            end
            if (state_r == ST_RD_DONE) begin
                snap_value_r <= {avm_readdata, snap_lo_r};
            end
            if (state_r == ST_WR_CTL) begin
                running_r <= 1'b1;
            end else if (state_r == ST_WR_STOP) begin
                running_r <= 1'b0;
            end
        end
    end

    assign avm_address    = avm_address_r;
    assign avm_chipselect = avm_chipselect_r;
    assign avm_write_n    = avm_write_n_r;
    assign avm_writedata  = avm_writedata_r;
    assign busy           = busy_r;
    assign running        = running_r;
    assign tick           = tick_r;
    assign tick_count     = tick_count_r;
    assign snap_valid     = snap_valid_r;
    assign snap_value     = snap_value_r;

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Directed bench for timer_ctrl_master: a sequence-level reference model checked every
// cycle, a small timer-slave responder, and literal expectations per scenario.
module tb_timer_ctrl_master;

    localparam int CNT_W = 16;
    localparam int EF_NONE = 0, EF_RUN_ON = 1, EF_RUN_OFF = 2, EF_TICK = 3, EF_LATCH = 4, EF_SNAP = 5;

    typedef struct {
        logic        cs;
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] data;
        int          eff;
    } op_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_start = 1'b0, cfg_stop = 1'b0, cfg_snap = 1'b0;
    logic [31:0]      cfg_period = 32'h0;
    logic             cfg_continuous = 1'b0;
    logic             timer_irq = 1'b0;
    logic [2:0]       avm_address;
    logic             avm_chipselect, avm_write_n;
    logic [15:0]      avm_writedata;
    logic [15:0]      avm_readdata = 16'h0;
    logic             busy, running, tick, snap_valid;
    logic [CNT_W-1:0] tick_count;
    logic [31:0]      snap_value;

    int n_chk = 0;
    int n_fail = 0;

    timer_ctrl_master #(.CNT_W(CNT_W), .CTL_ITO(1'b1)) dut (
        .clk(clk), .reset(reset),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_snap(cfg_snap),
        .cfg_period(cfg_period), .cfg_continuous(cfg_continuous), .timer_irq(timer_irq),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .busy(busy), .running(running), .tick(tick), .tick_count(tick_count),
        .snap_valid(snap_valid), .snap_value(snap_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timer slave: snapshot latch, registered readdata, IRQ that lingers one cycle after ack.
    logic [31:0] tb_counter = 32'h0;
    logic [31:0] snap_reg = 32'h0;
    logic        irq_set = 1'b0;
    logic        irq_clr_pend = 1'b0;
    always @(posedge clk) begin
        if (avm_chipselect && !avm_write_n && avm_address == 3'd4) snap_reg <= tb_counter;
        if (avm_chipselect && avm_write_n && avm_address == 3'd4) avm_readdata <= snap_reg[15:0];
        else if (avm_chipselect && avm_write_n && avm_address == 3'd5) avm_readdata <= snap_reg[31:16];
        else avm_readdata <= 16'h0000;
        if (irq_clr_pend) begin
            timer_irq <= 1'b0;
            irq_clr_pend <= 1'b0;
        end else if (avm_chipselect && !avm_write_n && avm_address == 3'd0) begin
            irq_clr_pend <= 1'b1;
        end
        if (irq_set) timer_irq <= 1'b1;
    end

    // Bus transaction log: {write, address, data (0 for reads)}.
    logic [19:0] bus_log[$];
    always @(posedge clk) begin
        if (!reset && avm_chipselect)
            bus_log.push_back({~avm_write_n, avm_address, avm_write_n ? 16'h0000 : avm_writedata});
    end

    // Reference model: each accepted request expands into its list of bus cycles.
    op_t         q[$];
    logic        m_ps, m_pt, m_pn, m_running, m_tick, m_sv;
    logic [CNT_W-1:0] m_count;
    logic [31:0] m_snap, m_lat;
    logic        rs, rt, rn, was_idle;
    op_t         cur;

    function automatic void push_op(logic cs, logic wr, logic [2:0] a, logic [15:0] d, int e);
        op_t o;
        o.cs = cs; o.wr = wr; o.addr = a; o.data = d; o.eff = e;
        q.push_back(o);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_ps = 1'b0; m_pt = 1'b0; m_pn = 1'b0;
            m_running = 1'b0; m_tick = 1'b0; m_sv = 1'b0;
            m_count = '0; m_snap = 32'h0; m_lat = 32'h0;
        end else begin
            was_idle = (q.size() == 0);
            m_tick = 1'b0;
            m_sv = 1'b0;
            if (!was_idle) begin
                cur = q.pop_front();
                case (cur.eff)
                    EF_RUN_ON:  m_running = 1'b1;
                    EF_RUN_OFF: m_running = 1'b0;
                    EF_TICK:    begin m_tick = 1'b1; m_count = m_count + 1'b1; end
                    EF_LATCH:   m_lat = tb_counter;
                    EF_SNAP:    begin m_sv = 1'b1; m_snap = m_lat; end
                    default:    ;
                endcase
            end
            rs = m_ps | cfg_stop;
            rt = m_pt | cfg_start;
            rn = m_pn | cfg_snap;
            if (was_idle) begin
                if (rs) begin
                    push_op(1'b1, 1'b1, 3'd1, 16'h0008, EF_RUN_OFF);
                    rs = 1'b0;
                    rt = 1'b0;
                end else if (rt) begin
                    push_op(1'b1, 1'b1, 3'd2, cfg_period[15:0], EF_NONE);
                    push_op(1'b1, 1'b1, 3'd3, cfg_period[31:16], EF_NONE);
                    push_op(1'b1, 1'b1, 3'd1, {13'h0, 1'b1, cfg_continuous, 1'b1}, EF_RUN_ON);
                    rt = 1'b0;
                end else if (timer_irq) begin
                    push_op(1'b1, 1'b1, 3'd0, 16'h0000, EF_TICK);
                    push_op(1'b0, 1'b0, 3'd0, 16'h0000, EF_NONE);
                end else if (rn) begin
                    push_op(1'b1, 1'b1, 3'd4, 16'h0000, EF_LATCH);
                    push_op(1'b1, 1'b0, 3'd4, 16'h0000, EF_NONE);
                    push_op(1'b1, 1'b0, 3'd5, 16'h0000, EF_NONE);
                    push_op(1'b0, 1'b0, 3'd0, 16'h0000, EF_SNAP);
                    rn = 1'b0;
                end
            end
            m_ps = rs; m_pt = rt; m_pn = rn;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    int tick_seen = 0;
    int sv_seen = 0;
    always @(negedge clk) begin
        op_t e;
        if (q.size() > 0) e = q[0];
        else begin e.cs = 1'b0; e.wr = 1'b0; e.addr = 3'd0; e.data = 16'h0; e.eff = EF_NONE; end
        chk("chipselect", {31'h0, avm_chipselect}, {31'h0, e.cs});
        chk("write_n", {31'h0, avm_write_n}, {31'h0, ~(e.cs & e.wr)});
        chk("address", {29'h0, avm_address}, {29'h0, e.addr});
        if (e.cs && e.wr) chk("writedata", {16'h0, avm_writedata}, {16'h0, e.data});
        chk("busy", {31'h0, busy}, {31'h0, (q.size() > 0)});
        chk("running", {31'h0, running}, {31'h0, m_running});
        chk("tick", {31'h0, tick}, {31'h0, m_tick});
        chk("tick_count", {16'h0, tick_count}, {16'h0, m_count});
        chk("snap_valid", {31'h0, snap_valid}, {31'h0, m_sv});
        chk("snap_value", snap_value, m_snap);
        if (tick) tick_seen++;
        if (snap_valid) sv_seen++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        step(1);
        while (busy && n < 100) begin
            step(1);
            n++;
        end
        chk("wait_idle_timeout", {31'h0, (n < 100)}, 32'h1);
    endtask

    task automatic chk_log(input string nm, input int idx, input logic [19:0] exp);
        if (idx < bus_log.size()) chk(nm, {12'h0, bus_log[idx]}, {12'h0, exp});
        else chk(nm, 32'hFFFF_FFFF, {12'h0, exp});
    endtask

    initial begin
        step(3);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_cs", {31'h0, avm_chipselect}, 32'h0);
        end
        chk("reset_tick_count", {16'h0, tick_count}, 32'h0);
        chk("reset_snap_value", snap_value, 32'h0);
        step(1);

        // Start with continuous mode
        bus_log.delete();
        cfg_period = 32'h0001_86A0; cfg_continuous = 1'b1;
        cfg_start = 1'b1; step(1); cfg_start = 1'b0;
        wait_idle();
        chk("start_len", bus_log.size(), 32'd3);
        chk_log("start_pl", 0, {1'b1, 3'd2, 16'h86A0});
        chk_log("start_ph", 1, {1'b1, 3'd3, 16'h0001});
        chk_log("start_ctl", 2, {1'b1, 3'd1, 16'h0007});
        chk("start_running", {31'h0, running}, 32'h1);
        chk("model_running", {31'h0, m_running}, 32'h1);

        // Timeout acknowledge with IRQ lingering through the gap cycle
        step(2);
        bus_log.delete(); tick_seen = 0;
        irq_set = 1'b1; step(1); irq_set = 1'b0;
        step(8);
        chk("ack_len", bus_log.size(), 32'd1);
        chk_log("ack_wr", 0, {1'b1, 3'd0, 16'h0000});
        chk("ack_ticks", tick_seen, 32'd1);
        chk("ack_count", {16'h0, tick_count}, 32'd1);
        chk("model_count", {16'h0, m_count}, 32'd1);

        // Snapshot read
        tb_counter = 32'h0000_1234;
        bus_log.delete(); sv_seen = 0;
        cfg_snap = 1'b1; step(1); cfg_snap = 1'b0;
        wait_idle();
        step(1);
        chk("snap_len", bus_log.size(), 32'd3);
        chk_log("snap_wr", 0, {1'b1, 3'd4, 16'h0000});
        chk_log("snap_rl", 1, {1'b0, 3'd4, 16'h0000});
        chk_log("snap_rh", 2, {1'b0, 3'd5, 16'h0000});
        chk("snap_value_lit", snap_value, 32'h0000_1234);
        chk("snap_valid_pulses", sv_seen, 32'd1);

        // Start and stop in the same cycle: only the stop write
        bus_log.delete();
        cfg_start = 1'b1; cfg_stop = 1'b1; step(1); cfg_start = 1'b0; cfg_stop = 1'b0;
        wait_idle();
        step(3);
        chk("ss_len", bus_log.size(), 32'd1);
        chk_log("ss_stop", 0, {1'b1, 3'd1, 16'h0008});
        chk("ss_running", {31'h0, running}, 32'h0);

        // Snap requested mid-start runs after the control write
        tb_counter = 32'hCAFE_0042;
        cfg_period = 32'hDEAD_BEEF; cfg_continuous = 1'b0;
        bus_log.delete();
        cfg_start = 1'b1; step(1); cfg_start = 1'b0;
        cfg_snap = 1'b1; step(1); cfg_snap = 1'b0;
        step(12);
        chk("ms_len", bus_log.size(), 32'd6);
        chk_log("ms_pl", 0, {1'b1, 3'd2, 16'hBEEF});
        chk_log("ms_ph", 1, {1'b1, 3'd3, 16'hDEAD});
        chk_log("ms_ctl", 2, {1'b1, 3'd1, 16'h0005});
        chk_log("ms_snap", 3, {1'b1, 3'd4, 16'h0000});
        chk("ms_value", snap_value, 32'hCAFE_0042);
        chk("ms_running", {31'h0, running}, 32'h1);

        // Reset while in RD_SH aborts without further bus activity
        cfg_snap = 1'b1; step(1); cfg_snap = 1'b0;
        step(2);
        chk("pre_reset_addr", {29'h0, avm_address}, 32'd5);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_cs", {31'h0, avm_chipselect}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_snap", snap_value, 32'h0);
        step(1);
        reset = 1'b0;
        bus_log.delete();
        step(6);
        chk("post_reset_quiet", bus_log.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
